// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST       = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one req/ack read at a time,
// buffers a word while decode stalls and strobes {pc+4, inst} into the IF/ID latch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              write_o,
  output logic [ADDR_W-1:0] pc_add4_o,
  output logic [31:0]       inst_o
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [31:0]       buf_inst_q, buf_inst_d;
  logic [ADDR_W-1:0] buf_pc4_q, buf_pc4_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;

  logic [ADDR_W-1:0] tgt_aligned;
  logic [ADDR_W-1:0] pc_inc;

  assign tgt_aligned = {target_i[ADDR_W-1:2], 2'b00};
  assign pc_inc      = pc_q + ADDR_W'(4);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    buf_inst_d = buf_inst_q;
    buf_pc4_d  = buf_pc4_q;
    req_d      = req_q;
    addr_d     = addr_q;
    write_d    = 1'b0;
    inst_d     = inst_q;
    pc4_d      = pc4_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end

      REQ: begin
        if (imem_ack_i) begin
          if (redirect_i) begin
            pc_d   = tgt_aligned;
            addr_d = tgt_aligned;
          end else if (hold_i) begin
            buf_inst_d = imem_rdata_i;
            buf_pc4_d  = pc_inc;
            state_d    = HOLD;
            req_d      = 1'b0;
          end else begin
            write_d = 1'b1;
            inst_d  = imem_rdata_i;
            pc4_d   = pc_inc;
            pc_d    = pc_inc;
            addr_d  = pc_inc;
          end
        end else if (redirect_i) begin
          // The address must stay put until the outstanding read is acked.
          tgt_d   = tgt_aligned;
          state_d = DROP;
        end
      end

      DROP: begin
        if (imem_ack_i) begin
          pc_d    = redirect_i ? tgt_aligned : tgt_q;
          addr_d  = redirect_i ? tgt_aligned : tgt_q;
          state_d = REQ;
        end else if (redirect_i) begin
          tgt_d = tgt_aligned;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          buf_inst_d = NOP_INST;
          pc_d       = tgt_aligned;
          addr_d     = tgt_aligned;
          req_d      = 1'b1;
          state_d    = REQ;
        end else if (!hold_i) begin
          write_d = 1'b1;
          inst_d  = buf_inst_q;
          pc4_d   = buf_pc4_q;
          pc_d    = buf_pc4_q;
          addr_d  = buf_pc4_q;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      buf_inst_q <= NOP_INST;
      buf_pc4_q  <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      inst_q     <= NOP_INST;
      pc4_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      buf_inst_q <= buf_inst_d;
      buf_pc4_q  <= buf_pc4_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      inst_q     <= inst_d;
      pc4_q      <= pc4_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign write_o     = write_q;
  assign inst_o      = inst_q;
  assign pc_add4_o   = pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, hold, redirects, PC wrap and reset mid-request.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        hold_i;
  logic        redirect_i;
  logic [31:0] target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        write_o;
  logic [31:0] pc_add4_o;
  logic [31:0] inst_o;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hold_i      (hold_i),
    .redirect_i  (redirect_i),
    .target_i    (target_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_rdata_i(imem_rdata_i),
    .write_o     (write_o),
    .pc_add4_o   (pc_add4_o),
    .inst_o      (inst_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic wr, input logic [31:0] inst, input logic [31:0] pc4);
    check({tag, ".req"},   {31'd0, imem_req_o}, {31'd0, req});
    check({tag, ".addr"},  imem_addr_o, addr);
    check({tag, ".write"}, {31'd0, write_o}, {31'd0, wr});
    check({tag, ".inst"},  inst_o, inst);
    check({tag, ".pc4"},   pc_add4_o, pc4);
  endtask

  initial begin
    rst_i = 1'b0; hold_i = 1'b0; redirect_i = 1'b0; target_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    tick(); tick();
    check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    rst_i = 1'b1;
    tick();
    check_out("first_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // 1: ack every cycle, rdata = address
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0;
    tick(); check_out("stream0", 1'b1, 32'h4, 1'b1, 32'h0, 32'h4);
    imem_rdata_i = 32'h4;
    tick(); check_out("stream1", 1'b1, 32'h8, 1'b1, 32'h4, 32'h8);

    // 2: hold on ack of address 8 for three cycles
    imem_rdata_i = 32'h8; hold_i = 1'b1;
    tick(); check_out("hold1", 1'b0, 32'h8, 1'b0, 32'h4, 32'h8);
    imem_ack_i = 1'b0;
    tick(); check_out("hold2", 1'b0, 32'h8, 1'b0, 32'h4, 32'h8);
    tick(); check_out("hold3", 1'b0, 32'h8, 1'b0, 32'h4, 32'h8);
    hold_i = 1'b0;
    tick(); check_out("release", 1'b1, 32'hC, 1'b1, 32'h8, 32'hC);
    tick(); check_out("pulse_end", 1'b1, 32'hC, 1'b0, 32'h8, 32'hC);

    // 3: redirect mid-request, ack two cycles later is dropped
    redirect_i = 1'b1; target_i = 32'h40;
    tick(); check_out("drop1", 1'b1, 32'hC, 1'b0, 32'h8, 32'hC);
    redirect_i = 1'b0; target_i = '0;
    tick(); check_out("drop2", 1'b1, 32'hC, 1'b0, 32'h8, 32'hC);
    imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick(); check_out("drop_ack", 1'b1, 32'h40, 1'b0, 32'h8, 32'hC);
    imem_rdata_i = 32'h40;
    tick(); check_out("after_redir", 1'b1, 32'h44, 1'b1, 32'h40, 32'h44);

    // 4: redirect and hold together while holding; target low bits forced to 0
    imem_rdata_i = 32'h1234; hold_i = 1'b1;
    tick(); check_out("hold4", 1'b0, 32'h44, 1'b0, 32'h40, 32'h44);
    imem_ack_i = 1'b0; redirect_i = 1'b1; target_i = 32'h83;
    tick(); check_out("hold_redir", 1'b1, 32'h80, 1'b0, 32'h40, 32'h44);
    redirect_i = 1'b0; hold_i = 1'b0; target_i = '0;
    imem_ack_i = 1'b1; imem_rdata_i = 32'h80;
    tick(); check_out("tgt_fetch", 1'b1, 32'h84, 1'b1, 32'h80, 32'h84);

    // 5: PC wrap at the top of the address space
    imem_ack_i = 1'b0; redirect_i = 1'b1; target_i = 32'hFFFF_FFFC;
    tick(); check_out("wrap_drop", 1'b1, 32'h84, 1'b0, 32'h80, 32'h84);
    redirect_i = 1'b0; target_i = '0; imem_ack_i = 1'b1; imem_rdata_i = 32'h1111_1111;
    tick(); check_out("wrap_req", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h80, 32'h84);
    imem_rdata_i = 32'h0000_CAFE;
    tick(); check_out("wrap", 1'b1, 32'h0, 1'b1, 32'h0000_CAFE, 32'h0);

    // 6: reset with a request outstanding, stray ack afterwards
    imem_ack_i = 1'b0;
    tick(); check_out("outstanding", 1'b1, 32'h0, 1'b0, 32'h0000_CAFE, 32'h0);
    rst_i = 1'b0; imem_ack_i = 1'b1; imem_rdata_i = 32'h5555_5555;
    tick(); check_out("mid_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst_i = 1'b1;
    tick(); check_out("stray_ack", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    imem_rdata_i = 32'h77;
    tick(); check_out("restart", 1'b1, 32'h4, 1'b1, 32'h77, 32'h4);
    imem_ack_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
